imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered immediate-generation stage for the RISC-V cores: accepts a raw instruction and PC over a valid/ready handshake, decodes the instruction format from the opcode itself, builds the XLEN-wide immediate for every base format (I, S, B, U, J, shift-amount, CSR zimm), and presents it one cycle later. It sits between fetch and the register-read/execute stages of the pipelined core. A two-entry skid buffer keeps full throughput with a registered `in_ready`.

## Interface
- `XLEN`, 32, datapath width; legal values 32 and 64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid`  in  1  upstream entry is valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  instruction passed through.
- `out_pc`  out  XLEN  PC passed through.
- `out_imm`  out  XLEN  generated immediate.
- `out_fmt`  out  3  format code (`imm_fmt_e`).
- `out_illegal`  out  1  opcode not supported for this XLEN.

## Operation
- Formats and immediates, with sign extension from `instr[31]` to XLEN:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`, sign-extended to XLEN.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - SH: zero-extended `instr[25:20]` when XLEN=64, otherwise `instr[24:20]`.
  - Z: zero-extended `instr[19:15]`.
  - NONE: immediate 0.
- Opcode decode:
  - LOAD 0000011 and JALR 1100111 → I.
  - OP-IMM 0010011 → SH if funct3 is 001 or 101, else I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - SYSTEM 1110011 → Z if funct3[2]=1, else I.
  - OP 0110011 → NONE.
  - OP-IMM-32 0011011 and OP-32 0111011: only when XLEN=64. OP-IMM-32 is SH (5-bit shamt) for funct3 001/101, else I; OP-32 is NONE.
  - Anything else → `out_illegal`=1, format NONE, immediate 0, entry still forwarded.
- Buffer state machine; a transfer occurs when valid and ready are both high on an interface. Payload is decoded on entry, so stored entries hold the decoded result.
  - EMPTY → ONE on input transfer.
  - ONE → EMPTY on output transfer with no input transfer.
  - ONE stays ONE on simultaneous input and output transfers; the main register is replaced.
  - ONE → TWO on input transfer with no output transfer; the new entry goes to the skid register.
  - TWO → ONE on output transfer; the skid entry moves to the main register.
- `in_ready` = (next state ≠ TWO), registered. It is 1 in EMPTY and ONE, and 0 in TWO.
- `out_valid` = (state ≠ EMPTY). Outputs always come from the main register.
- `flush`: next state is EMPTY. An input transfer in the same cycle is discarded, and `in_ready`=1 the following cycle. Flush takes priority over all transfers.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N, with `out_valid`=1.
- Throughput is 1 entry per cycle with `out_ready` held high.
- After reset: state EMPTY, `out_valid`=0, `in_ready`=1. `out_instr`, `out_pc`, `out_imm`, `out_fmt`, `out_illegal` reset to 0.
- Reset asserted mid-stream drops all entries immediately (asynchronous). The first transfer occurs on the first edge after deassertion.
- Output payload is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` never depends combinationally on `out_ready`.

## Structure
- Package `imm_pkg`:
  - `imm_fmt_e` with encodings NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7.
  - Opcode localparams.
  - Buffer state enum.
- Sub-module `imm_decode`: combinational; inputs `instr`; outputs `fmt`, `imm`, `illegal`. It carries the XLEN parameter.
- The top level holds the main and skid registers and the state machine.

## Test plan
- XLEN=32, `in_instr`=0xFFF00093 (addi x1,x0,-1) → next cycle `out_imm`=0xFFFFFFFF, `out_fmt`=I, `out_illegal`=0.
- `in_instr`=0xFE112E23 (sw x1,-4(x2)) → `out_imm`=0xFFFFFFFC, fmt S. Then 0xFFDFF06F (jal x0,-4) → `out_imm`=0xFFFFFFFC, fmt J.
- Wide immediates:
  - XLEN=32, 0x123450B7 → `out_imm`=0x12345000, fmt U.
  - XLEN=64, 0x800000B7 → `out_imm`=0xFFFFFFFF80000000.
  - XLEN=64, slli with shamt 33 → `out_imm`=33, fmt SH.
- Backpressure: stream A, B, C back-to-back with `out_ready`=0 → A on the output, B in the skid register, `in_ready`=0 after two accepts, C held. Release `out_ready` → A, B, C emitted in order, none lost or duplicated.
- In state TWO, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and neither the flushed entries nor the concurrent input is ever emitted.
- Decode corner cases:
  - Opcode 0x0000007F → `out_illegal`=1, `out_imm`=0.
  - XLEN=32 with OP-IMM-32 → illegal.
- Reset mid-stream: assert `reset` while in state ONE, asynchronously between edges → `out_valid`=0 immediately, all outputs 0.

Source files
------------

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared types and constants for the immediate-generation stage:
//   - imm_fmt_e   : immediate format code carried alongside each entry
//   - OPC_*       : RV32/RV64 base opcodes the decoder recognises
//   - buf_state_e : occupancy of the two-entry skid buffer
//   - is_shift_funct3 : OP-IMM / OP-IMM-32 shift detection helper
// -----------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // SLLI/SRLI/SRAI (and their W forms) use funct3 001 and 101.
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Combinational format classification and immediate assembly for one
// instruction word.
//   instr   in  32    raw instruction
//   fmt     out 3     format code (imm_fmt_e)
//   imm     out XLEN  sign/zero-extended immediate (0 for NONE / illegal)
//   illegal out 1     opcode not supported for this XLEN
// -----------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic            sh6_s;
  imm_fmt_e        fmt_s;
  logic            illegal_s;
  logic [XLEN-1:0] imm_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];

  // Classify the opcode into an immediate format and flag unsupported opcodes.
  always_comb begin
    fmt_s     = FMT_NONE;
    illegal_s = 1'b0;
    sh6_s     = 1'b0;
    case (opcode_s)
      OPC_LOAD, OPC_JALR: begin
        fmt_s = FMT_I;
      end
      OPC_OP_IMM: begin
        if (is_shift_funct3(funct3_s)) begin
          fmt_s = FMT_SH;
          // Only the full-width OP-IMM shifts get a 6-bit shamt on RV64.
          sh6_s = RV64;
        end else begin
          fmt_s = FMT_I;
        end
      end
      OPC_STORE: begin
        fmt_s = FMT_S;
      end
      OPC_BRANCH: begin
        fmt_s = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_s = FMT_U;
      end
      OPC_JAL: begin
        fmt_s = FMT_J;
      end
      OPC_SYSTEM: begin
        // CSR immediate forms (CSRRWI/CSRRSI/CSRRCI) have funct3[2] set.
        if (funct3_s[2]) begin
          fmt_s = FMT_Z;
        end else begin
          fmt_s = FMT_I;
        end
      end
      OPC_OP: begin
        fmt_s = FMT_NONE;
      end
      OPC_OP_IMM_32: begin
        if (!RV64) begin
          illegal_s = 1'b1;
        end else if (is_shift_funct3(funct3_s)) begin
          fmt_s = FMT_SH;
        end else begin
          fmt_s = FMT_I;
        end
      end
      OPC_OP_32: begin
        if (!RV64) begin
          illegal_s = 1'b1;
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      default: begin
        fmt_s     = FMT_NONE;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Assemble the immediate; sized casts of signed fields sign-extend to XLEN.
  always_comb begin
    imm_s = {XLEN{1'b0}};
    case (fmt_s)
      FMT_I:  imm_s = XLEN'($signed(instr[31:20]));
      FMT_S:  imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:  imm_s = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0}));
      FMT_U:  imm_s = XLEN'($signed({instr[31:12], 12'h000}));
      FMT_J:  imm_s = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0}));
      FMT_SH: begin
        if (sh6_s) begin
          imm_s = XLEN'(instr[25:20]);
        end else begin
          imm_s = XLEN'(instr[24:20]);
        end
      end
      FMT_Z:    imm_s = XLEN'(instr[19:15]);
      FMT_NONE: imm_s = {XLEN{1'b0}};
      default:  imm_s = {XLEN{1'b0}};
    endcase
  end

  assign fmt     = fmt_s;
  assign imm     = imm_s;
  assign illegal = illegal_s;

endmodule

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Registered immediate-generation stage with a two-entry skid buffer.
// The instruction is decoded on entry; the main register always feeds the
// outputs and the skid register absorbs one extra entry so that in_ready can
// be registered without losing throughput.
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous discard of all buffered entries
//   in_valid/in_ready, in_instr[31:0], in_pc[XLEN-1:0]      upstream
//   out_valid/out_ready, out_instr, out_pc, out_imm, out_fmt, out_illegal
// -----------------------------------------------------------------------------
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal
);

  buf_state_e      state_r;
  buf_state_e      next_state_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            in_xfer_s;
  logic            out_xfer_s;
  logic            load_main_s;
  logic            load_skid_s;
  logic            move_skid_s;
  logic            in_ready_next_s;
  logic            out_valid_next_s;

  imm_fmt_e        dec_fmt_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_illegal_s;

  logic [31:0]     main_instr_r;
  logic [XLEN-1:0] main_pc_r;
  logic [XLEN-1:0] main_imm_r;
  imm_fmt_e        main_fmt_r;
  logic            main_illegal_r;

  logic [31:0]     skid_instr_r;
  logic [XLEN-1:0] skid_pc_r;
  logic [XLEN-1:0] skid_imm_r;
  imm_fmt_e        skid_fmt_r;
  logic            skid_illegal_r;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (in_instr),
    .fmt     (dec_fmt_s),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Buffer state and registered handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= BUF_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  // Next-state logic; flush overrides every transfer.
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = BUF_EMPTY;
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          if (in_xfer_s) begin
            next_state_s = BUF_ONE;
          end else begin
            next_state_s = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          if (in_xfer_s && !out_xfer_s) begin
            next_state_s = BUF_TWO;
          end else if (!in_xfer_s && out_xfer_s) begin
            next_state_s = BUF_EMPTY;
          end else begin
            next_state_s = BUF_ONE;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer_s) begin
            next_state_s = BUF_ONE;
          end else begin
            next_state_s = BUF_TWO;
          end
        end
        default: begin
          next_state_s = BUF_EMPTY;
        end
      endcase
    end
  end

  // Datapath steering and next values of the registered handshake flags.
  always_comb begin
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    move_skid_s = 1'b0;
    if (flush) begin
      load_main_s = 1'b0;
      load_skid_s = 1'b0;
      move_skid_s = 1'b0;
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          load_main_s = in_xfer_s;
        end
        BUF_ONE: begin
          // Simultaneous in/out replaces the main entry; in-only parks in skid.
          load_main_s = in_xfer_s & out_xfer_s;
          load_skid_s = in_xfer_s & ~out_xfer_s;
        end
        BUF_TWO: begin
          move_skid_s = out_xfer_s;
        end
        default: begin
          load_main_s = 1'b0;
        end
      endcase
    end
    in_ready_next_s  = (next_state_s != BUF_TWO);
    out_valid_next_s = (next_state_s != BUF_EMPTY);
  end

  // Main register: loaded from the decoder or promoted from the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_instr_r   <= 32'h0000_0000;
      main_pc_r      <= {XLEN{1'b0}};
      main_imm_r     <= {XLEN{1'b0}};
      main_fmt_r     <= FMT_NONE;
      main_illegal_r <= 1'b0;
    end else if (load_main_s) begin
      main_instr_r   <= in_instr;
      main_pc_r      <= in_pc;
      main_imm_r     <= dec_imm_s;
      main_fmt_r     <= dec_fmt_s;
      main_illegal_r <= dec_illegal_s;
    end else if (move_skid_s) begin
      main_instr_r   <= skid_instr_r;
      main_pc_r      <= skid_pc_r;
      main_imm_r     <= skid_imm_r;
      main_fmt_r     <= skid_fmt_r;
      main_illegal_r <= skid_illegal_r;
    end
  end

  // Skid register: holds the second entry while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_instr_r   <= 32'h0000_0000;
      skid_pc_r      <= {XLEN{1'b0}};
      skid_imm_r     <= {XLEN{1'b0}};
      skid_fmt_r     <= FMT_NONE;
      skid_illegal_r <= 1'b0;
    end else if (load_skid_s) begin
      skid_instr_r   <= in_instr;
      skid_pc_r      <= in_pc;
      skid_imm_r     <= dec_imm_s;
      skid_fmt_r     <= dec_fmt_s;
      skid_illegal_r <= dec_illegal_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_instr   = main_instr_r;
  assign out_pc      = main_pc_r;
  assign out_imm     = main_imm_r;
  assign out_fmt     = main_fmt_r;
  assign out_illegal = main_illegal_r;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Drives an XLEN=32 and an XLEN=64 instance with the same stimulus: a table of
// directed decode vectors, hand-written handshake sequences, and a random
// phase checked against a queue-based occupancy model and a field-arithmetic
// immediate reference.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_instr, r32_out_pc, r32_out_imm;
  logic [2:0]  r32_out_fmt;
  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [31:0] r64_out_instr;
  logic [63:0] r64_out_pc, r64_out_imm;
  logic [2:0]  r64_out_fmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_instr(r32_out_instr), .out_pc(r32_out_pc), .out_imm(r32_out_imm),
    .out_fmt(r32_out_fmt), .out_illegal(r32_out_illegal)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_instr(r64_out_instr), .out_pc(r64_out_pc), .out_imm(r64_out_imm),
    .out_fmt(r64_out_fmt), .out_illegal(r64_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32; logic [2:0] fmt32; logic ill32;
    logic [63:0] imm64; logic [2:0] fmt64; logic ill64;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input logic vld, input logic rdy);
    chk({tag, ".valid32"}, {63'd0, r32_out_valid}, {63'd0, vld});
    chk({tag, ".ready32"}, {63'd0, r32_in_ready},  {63'd0, rdy});
    chk({tag, ".valid64"}, {63'd0, r64_out_valid}, {63'd0, vld});
    chk({tag, ".ready64"}, {63'd0, r64_in_ready},  {63'd0, rdy});
  endtask

  // Reference decode: formats from the opcode table, immediates from
  // weighted field sums with two's-complement correction.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    logic [6:0] op;
    logic [2:0] f3;
    longint     v;
    bit         shift;
    bit         wide_sh;
    op = ins[6:0];
    f3 = ins[14:12];
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    fmt = 3'd0; ill = 1'b0; wide_sh = 1'b0; v = 0;
    case (op)
      7'h03, 7'h67: fmt = 3'd1;
      7'h13: begin fmt = shift ? 3'd6 : 3'd1; wide_sh = x64; end
      7'h23: fmt = 3'd2;
      7'h63: fmt = 3'd3;
      7'h37, 7'h17: fmt = 3'd4;
      7'h6F: fmt = 3'd5;
      7'h73: fmt = ins[14] ? 3'd7 : 3'd1;
      7'h33: fmt = 3'd0;
      7'h1B: if (x64) fmt = shift ? 3'd6 : 3'd1; else ill = 1'b1;
      7'h3B: if (!x64) ill = 1'b1;
      default: ill = 1'b1;
    endcase
    case (fmt)
      3'd1: begin v = longint'(ins[31:20]); if (ins[31]) v -= 4096; end
      3'd2: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (ins[31]) v -= 4096; end
      3'd3: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 8192;
      end
      3'd4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= 64'sd4294967296; end
      3'd5: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= 2097152;
      end
      3'd6: v = wide_sh ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd7: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    imm = v;
    if (!x64) imm = {32'd0, imm[31:0]};
  endfunction

  // Compare the payload of both instances against the reference for one entry.
  task automatic chk_entry(input string tag, input logic [31:0] ins, input logic [63:0] pc);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    ref_dec(ins, 1'b0, e_imm, e_fmt, e_ill);
    chk({tag, ".instr32"}, {32'd0, r32_out_instr}, {32'd0, ins});
    chk({tag, ".pc32"},    {32'd0, r32_out_pc},    {32'd0, pc[31:0]});
    chk({tag, ".imm32"},   {32'd0, r32_out_imm},   e_imm);
    chk({tag, ".fmt32"},   {61'd0, r32_out_fmt},   {61'd0, e_fmt});
    chk({tag, ".ill32"},   {63'd0, r32_out_illegal}, {63'd0, e_ill});
    ref_dec(ins, 1'b1, e_imm, e_fmt, e_ill);
    chk({tag, ".instr64"}, {32'd0, r64_out_instr}, {32'd0, ins});
    chk({tag, ".pc64"},    r64_out_pc,             pc);
    chk({tag, ".imm64"},   r64_out_imm,            e_imm);
    chk({tag, ".fmt64"},   {61'd0, r64_out_fmt},   {61'd0, e_fmt});
    chk({tag, ".ill64"},   {63'd0, r64_out_illegal}, {63'd0, e_ill});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [19];
  ent_t        q [$];
  logic [6:0]  ops [14];

  initial begin
    logic [31:0] va, vb, vc, r;
    bit          in_x, out_x;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
    vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[4]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[5]  = '{32'h02109093, 32'h00000001, 3'd6, 1'b0, 64'h0000000000000021, 3'd6, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[7]  = '{32'hFFF0009B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[8]  = '{32'h0050909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000005, 3'd6, 1'b0};
    vecs[9]  = '{32'h000000E3, 32'h00000800, 3'd3, 1'b0, 64'h0000000000000800, 3'd3, 1'b0};
    vecs[10] = '{32'h300FD073, 32'h0000001F, 3'd7, 1'b0, 64'h000000000000001F, 3'd7, 1'b0};
    vecs[11] = '{32'h30009073, 32'h00000300, 3'd1, 1'b0, 64'h0000000000000300, 3'd1, 1'b0};
    vecs[12] = '{32'h003100B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[13] = '{32'h003100BB, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[14] = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0};
    vecs[15] = '{32'h7FF02083, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0};
    vecs[16] = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
    vecs[17] = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0};
    vecs[18] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};

    ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h73, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h0B};

    // Reset state
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 64'h0;
    #12;
    chk_hs("reset", 1'b0, 1'b1);
    chk("reset.imm32", {32'd0, r32_out_imm}, 64'd0);
    chk("reset.imm64", r64_out_imm, 64'd0);
    chk("reset.pc64", r64_out_pc, 64'd0);
    chk("reset.fmt64", {61'd0, r64_out_fmt}, 64'd0);
    step();
    reset = 1'b0;

    // Table vectors streamed back-to-back with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 64'hA000_0000_0000_1000 + 64'(i) * 64'd4;
      step();
      chk_hs($sformatf("vec%0d", i), 1'b1, 1'b1);
      chk($sformatf("vec%0d.imm32", i), {32'd0, r32_out_imm}, {32'd0, vecs[i].imm32});
      chk($sformatf("vec%0d.fmt32", i), {61'd0, r32_out_fmt}, {61'd0, vecs[i].fmt32});
      chk($sformatf("vec%0d.ill32", i), {63'd0, r32_out_illegal}, {63'd0, vecs[i].ill32});
      chk($sformatf("vec%0d.imm64", i), r64_out_imm, vecs[i].imm64);
      chk($sformatf("vec%0d.fmt64", i), {61'd0, r64_out_fmt}, {61'd0, vecs[i].fmt64});
      chk($sformatf("vec%0d.ill64", i), {63'd0, r64_out_illegal}, {63'd0, vecs[i].ill64});
      chk($sformatf("vec%0d.pc64", i), r64_out_pc, in_pc);
    end
    in_valid = 1'b0;
    step();
    chk_hs("drain", 1'b0, 1'b1);

    // Backpressure: A, B, C with the output stalled.
    va = 32'h00100093; vb = 32'h00200093; vc = 32'h00300093;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = va; in_pc = 64'h100;
    step();
    chk_hs("bp.a", 1'b1, 1'b1);
    chk("bp.a.instr", {32'd0, r32_out_instr}, {32'd0, va});
    in_instr = vb; in_pc = 64'h104;
    step();
    chk_hs("bp.b", 1'b1, 1'b0);
    chk("bp.b.instr", {32'd0, r64_out_instr}, {32'd0, va});
    in_instr = vc; in_pc = 64'h108;
    step();
    chk_hs("bp.hold", 1'b1, 1'b0);
    chk_entry("bp.hold", va, 64'h100);
    out_ready = 1'b1;
    step();
    chk_hs("bp.rel1", 1'b1, 1'b1);
    chk_entry("bp.rel1", vb, 64'h104);
    step();
    chk_hs("bp.rel2", 1'b1, 1'b1);
    chk_entry("bp.rel2", vc, 64'h108);
    in_valid = 1'b0;
    step();
    chk_hs("bp.done", 1'b0, 1'b1);

    // Flush in TWO together with an input.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = va; in_pc = 64'h200;
    step();
    in_instr = vb; in_pc = 64'h204;
    step();
    chk_hs("fl.two", 1'b1, 1'b0);
    flush = 1'b1; in_instr = vc; in_pc = 64'h208;
    step();
    chk_hs("fl.after", 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_hs($sformatf("fl.idle%0d", k), 1'b0, 1'b1);
    end

    // Asynchronous reset while holding one entry.
    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFFF00093; in_pc = 64'hFFFF_0000_1234_5678;
    step();
    chk_hs("ar.one", 1'b1, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_hs("ar.now", 1'b0, 1'b1);
    chk("ar.instr32", {32'd0, r32_out_instr}, 64'd0);
    chk("ar.imm32", {32'd0, r32_out_imm}, 64'd0);
    chk("ar.pc64", r64_out_pc, 64'd0);
    chk("ar.imm64", r64_out_imm, 64'd0);
    chk("ar.fmt64", {61'd0, r64_out_fmt}, 64'd0);
    chk("ar.ill64", {63'd0, r64_out_illegal}, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk_hs("ar.idle", 1'b0, 1'b1);

    // Random traffic against the occupancy/queue model.
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      r         = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = {r[31:7], ops[$urandom_range(0, 13)]};
      in_pc     = {$urandom(), $urandom()};
      #3;
      chk_hs($sformatf("rnd%0d", c), (q.size() > 0), (q.size() < 2));
      if (q.size() > 0) chk_entry($sformatf("rnd%0d", c), q[0].instr, q[0].pc);
      in_x  = in_valid && (q.size() < 2);
      out_x = out_ready && (q.size() > 0);
      step();
      if (flush) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back('{in_instr, in_pc});
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
